// File: rtl/alu_issue_stage_if.sv
// ----------------------------------------------------------------------------
// alu_issue_stage_if
// Groups the signals of the decode/issue stage.
//   Upstream side : in_valid, in_ready, opcode, funct3, funct7_5, rs1_data,
//                   rs2_data, imm, rd_in, flush
//   EX side       : out_valid, out_ready, ALU_Cntrl, In1, In2, rd_out,
//                   illegal, illegal_cnt
// Modports:
//   master : the issue stage itself (it masters the registered bus into EX)
//   slave  : the surrounding pipeline (decoder feed and EX consumer)
// ----------------------------------------------------------------------------
interface alu_issue_stage_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic [WIDTH-1:0] imm;
  logic [4:0]       rd_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       ALU_Cntrl;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic [4:0]       rd_out;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    input  in_valid, opcode, funct3, funct7_5, rs1_data, rs2_data, imm,
           rd_in, flush, out_ready,
    output in_ready, out_valid, ALU_Cntrl, In1, In2, rd_out, illegal,
           illegal_cnt
  );

  modport slave (
    output in_valid, opcode, funct3, funct7_5, rs1_data, rs2_data, imm,
           rd_in, flush, out_ready,
    input  in_ready, out_valid, ALU_Cntrl, In1, In2, rd_out, illegal,
           illegal_cnt
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ----------------------------------------------------------------------------
// alu_issue_stage
// Decodes RV32 opcode/funct fields into the 4-bit ALU control code, selects
// operands In1/In2 and registers the result in a one-entry valid/ready stage
// (ID/EX boundary). Unsupported encodings are flagged and counted
// (saturating).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu_issue_stage_if.master (upstream handshake + EX outputs)
// ----------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_stage_if.master  bus
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE= 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [3:0]       w_ctl_p0;
  logic [WIDTH-1:0] w_in1_p0;
  logic [WIDTH-1:0] w_in2_p0;
  logic             w_ill_p0;
  logic             w_accept;

  logic             r_vld_p1;
  logic [3:0]       r_ctl_p1;
  logic [WIDTH-1:0] r_in1_p1;
  logic [WIDTH-1:0] r_in2_p1;
  logic [4:0]       r_rd_p1;
  logic             r_ill_p1;
  logic [CNT_W-1:0] r_ill_cnt;

  // ---- p0: combinational decode -------------------------------------------
  always_comb begin
    w_ctl_p0 = ALU_ADD;
    w_in1_p0 = bus.rs1_data;
    w_in2_p0 = bus.rs2_data;
    w_ill_p0 = 1'b0;
    unique case (bus.opcode)
      OP_R: begin
        unique case (bus.funct3)
          3'b000:  w_ctl_p0 = bus.funct7_5 ? ALU_SUB : ALU_ADD;
          3'b111:  begin w_ctl_p0 = ALU_AND; w_ill_p0 = bus.funct7_5; end
          3'b110:  begin w_ctl_p0 = ALU_OR;  w_ill_p0 = bus.funct7_5; end
          3'b100:  begin w_ctl_p0 = ALU_XOR; w_ill_p0 = bus.funct7_5; end
          3'b010:  begin w_ctl_p0 = ALU_SLT; w_ill_p0 = bus.funct7_5; end
          default: w_ill_p0 = 1'b1;
        endcase
      end
      OP_I: begin
        w_in2_p0 = bus.imm;
        unique case (bus.funct3)
          3'b000:  w_ctl_p0 = ALU_ADD;
          3'b111:  w_ctl_p0 = ALU_AND;
          3'b110:  w_ctl_p0 = ALU_OR;
          3'b100:  w_ctl_p0 = ALU_XOR;
          3'b010:  w_ctl_p0 = ALU_SLT;
          default: w_ill_p0 = 1'b1;
        endcase
      end
      OP_LOAD, OP_STORE: w_in2_p0 = bus.imm;
      OP_BR: begin
        // EQ/NE compare via SUB and Zero; LT/GE via SLT.
        unique case (bus.funct3)
          3'b000, 3'b001: w_ctl_p0 = ALU_SUB;
          3'b100, 3'b101: w_ctl_p0 = ALU_SLT;
          default:        w_ill_p0 = 1'b1;
        endcase
      end
      OP_LUI: begin
        w_in1_p0 = '0;
        w_in2_p0 = bus.imm;
      end
      default: w_ill_p0 = 1'b1;
    endcase
    // Illegal entries travel as a harmless ADD of zeros.
    if (w_ill_p0) begin
      w_ctl_p0 = ALU_ADD;
      w_in1_p0 = '0;
      w_in2_p0 = '0;
    end
  end

  // Flush blocks acceptance so a killed cycle never loads a new entry.
  assign bus.in_ready = (!r_vld_p1 || bus.out_ready) && !bus.flush;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // ---- p1: ID/EX register ---------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_ctl_p1  <= ALU_ADD;
      r_in1_p1  <= '0;
      r_in2_p1  <= '0;
      r_rd_p1   <= '0;
      r_ill_p1  <= 1'b0;
      r_ill_cnt <= '0;
    end else if (w_accept) begin
      r_vld_p1 <= 1'b1;
      r_ctl_p1 <= w_ctl_p0;
      r_in1_p1 <= w_in1_p0;
      r_in2_p1 <= w_in2_p0;
      r_rd_p1  <= bus.rd_in;
      r_ill_p1 <= w_ill_p0;
      if (w_ill_p0) r_ill_cnt <= sat_inc(r_ill_cnt);
    end else if (bus.flush || bus.out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign bus.out_valid   = r_vld_p1;
  assign bus.ALU_Cntrl   = r_ctl_p1;
  assign bus.In1         = r_in1_p1;
  assign bus.In2         = r_in2_p1;
  assign bus.rd_out      = r_rd_p1;
  assign bus.illegal     = r_ill_p1;
  assign bus.illegal_cnt = r_ill_cnt;

endmodule
